// File: rtl/spi_flash_reader_if.sv
// Bundles the flash-reader control, FIFO-push and SPI pins into one port.
// Latency: none; this is a bundle of wires only.
// Backpressure: space_available from the FIFO gates each byte push.
// Signals:
//   start/addr/len/busy/done : transaction request and status
//   space_available/write_data/write_strobe : byte FIFO write side
//   spi_cs_n/spi_sck/spi_mosi/spi_miso : serial flash pins
// Modports: slave = the reader block, master = its environment.
interface spi_flash_reader_if;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        space_available;
    logic [7:0]  write_data;
    logic        write_strobe;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    modport slave (
        input  start, addr, len, space_available, spi_miso,
        output busy, done, write_data, write_strobe, spi_cs_n, spi_sck, spi_mosi
    );

    modport master (
        output start, addr, len, space_available, spi_miso,
        input  busy, done, write_data, write_strobe, spi_cs_n, spi_sck, spi_mosi
    );
endinterface

// File: rtl/spi_flash_reader.sv
// Serial-flash READ engine: sends opcode+24-bit address, shifts bytes in, pushes them to a byte FIFO.
// Latency: first write_strobe 1 + 64*HALF (+16*HALF with dummy) + 1 + 16*HALF + 1 clk after accepted start.
// Backpressure: each byte starts only when space_available=1; SCK parks low while waiting.
// Ports: clk, reset (async, active high), bus (spi_flash_reader_if.slave).
// Parameters: HALF = SCK half-period in clk cycles, CS_IDLE = min cs_n high time between transactions.
// Option: define SPI_FLASH_FAST_READ_EN for opcode 0x0B plus 8 dummy SCK cycles.
module spi_flash_reader #(
    parameter int HALF    = 1,
    parameter int CS_IDLE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_flash_reader_if.slave     bus
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
`else
    localparam logic [7:0] OPCODE = 8'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DUMMY, S_WAIT, S_DATA, S_PUSH, S_END, S_HOLD
    } state_t;

    state_t      state_q;
    logic [31:0] sh_q;       // outgoing {opcode, addr}, MSB first
    logic [15:0] cnt_q;      // bytes still to push
    logic [15:0] div_q;      // clk cycles within the current SCK half-period
    logic [4:0]  bit_q;      // SCK cycles completed in the current phase
    logic [15:0] hold_q;
    logic [7:0]  rx_q;
    logic [7:0]  wdata_q;
    logic        wstrb_q;
    logic        busy_q;
    logic        done_q;
    logic        cs_n_q;
    logic        sck_q;
    logic        mosi_q;
    logic        tick;

    // Last clk of a half-period: the edge that toggles SCK.
    assign tick = (div_q == 16'(HALF - 1));

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.write_data   = wdata_q;
    assign bus.write_strobe = wstrb_q;
    assign bus.spi_cs_n     = cs_n_q;
    assign bus.spi_sck      = sck_q;
    assign bus.spi_mosi     = mosi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            rx_q    <= '0;
            wdata_q <= '0;
            wstrb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            wstrb_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A zero-length request is dropped without touching the bus.
                    if (bus.start && (bus.len != 16'd0)) begin
                        sh_q    <= {OPCODE, bus.addr};
                        cnt_q   <= bus.len;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        mosi_q  <= OPCODE[7];
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (tick) begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            // Falling edge: present the next command bit.
                            sck_q <= 1'b0;
                            if (bit_q == 5'd31) begin
                                bit_q  <= '0;
                                mosi_q <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
                                state_q <= S_DUMMY;
`else
                                state_q <= S_WAIT;
`endif
                            end else begin
                                bit_q  <= bit_q + 5'd1;
                                sh_q   <= sh_q << 1;
                                mosi_q <= sh_q[30];
                            end
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                S_DUMMY: begin
                    // Eight idle SCK cycles; miso is not sampled here.
                    if (tick) begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == 5'd7) begin
                                bit_q   <= '0;
                                state_q <= S_WAIT;
                            end else begin
                                bit_q <= bit_q + 5'd1;
                            end
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
`endif
                S_WAIT: begin
                    if (bus.space_available) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        div_q <= '0;
                        if (!sck_q) begin
                            // Mode 0: sample on the rising edge.
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[6:0], bus.spi_miso};
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == 5'd7) begin
                                state_q <= S_PUSH;
                            end else begin
                                bit_q <= bit_q + 5'd1;
                            end
                        end
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                S_PUSH: begin
                    wstrb_q <= 1'b1;
                    wdata_q <= rx_q;
                    cnt_q   <= cnt_q - 16'd1;
                    state_q <= (cnt_q == 16'd1) ? S_END : S_WAIT;
                end
                S_END: begin
                    cs_n_q  <= 1'b1;
                    done_q  <= 1'b1;
                    hold_q  <= '0;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // busy stays high so no new start can shorten the cs_n gap.
                    if (hold_q == 16'(CS_IDLE - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        hold_q <= hold_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural flash + byte scoreboard, random addresses/lengths/backpressure.
// Latency: expected first-strobe timing from the documented formula.
// Backpressure: drives space_available directly, or randomly per clk.
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         HALF = 2;
    localparam logic [7:0] OPC  = 8'h0B;
    localparam int         HDR  = 40;
`else
    localparam int         HALF = 1;
    localparam logic [7:0] OPC  = 8'h03;
    localparam int         HDR  = 32;
`endif
    localparam int CS_IDLE = 4;
    localparam int LAT     = 1 + 2 * HALF * HDR + 1 + 16 * HALF + 1;
    localparam int SPACING = 16 * HALF + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_flash_reader_if sif ();

    spi_flash_reader #(.HALF(HALF), .CS_IDLE(CS_IDLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Backpressure source: held value or a fresh random bit per clk.
    logic space_hold;
    logic rnd_space;
    logic rnd_bit;
    assign sif.space_available = rnd_space ? rnd_bit : space_hold;
    always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);

    // Behavioural flash: 256-byte image repeated across the address space.
    logic [7:0]  mem [256];
    int          rises;
    int          rise_tot;
    int          mosi_extra;
    logic [31:0] cmd_sr;
    int          fk;
    logic [7:0]  fb;

    initial begin
        rises = 0;
        rise_tot = 0;
        mosi_extra = 0;
        cmd_sr = '0;
        sif.spi_miso = 1'b0;
    end

    always @(posedge sif.spi_sck) begin
        rise_tot++;
        if (sif.spi_cs_n === 1'b0) begin
            if (rises < 32) cmd_sr = {cmd_sr[30:0], sif.spi_mosi};
            else if (sif.spi_mosi !== 1'b0) mosi_extra++;
            rises++;
        end
    end

    always @(negedge sif.spi_sck) begin
        if (sif.spi_cs_n === 1'b0) begin
            if (rises >= HDR) begin
                fk = rises - HDR;
                fb = mem[8'(cmd_sr[7:0] + 8'(fk / 8))];
                sif.spi_miso = fb[7 - (fk % 8)];
            end else begin
                sif.spi_miso = 1'($urandom_range(0, 1));
            end
        end
    end

    always @(posedge sif.spi_cs_n) rises = 0;

    // Output monitor.
    logic [7:0] obs_q [$];
    int         obs_cyc [$];
    logic [7:0] exp_q [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int hi_run = 0;
    int last_hi_run = 0;
    logic cs_prev = 1'b1;
    int t0 = 0;

    always @(negedge clk) begin
        if (sif.write_strobe === 1'b1) begin
            obs_q.push_back(sif.write_data);
            obs_cyc.push_back(cyc);
        end
        if (sif.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (sif.spi_cs_n !== 1'b0) begin
            hi_run++;
        end else begin
            if (cs_prev) last_hi_run = hi_run;
            hi_run = 0;
        end
        cs_prev = (sif.spi_cs_n !== 1'b0);
    end

    task automatic start_txn(input logic [23:0] a, input int l);
        for (int i = 0; i < 4000 && sif.busy !== 1'b0; i++) @(negedge clk);
        chk("idle_before_start", 32'(sif.busy), 32'd0);
        exp_q = {};
        for (int i = 0; i < l; i++) exp_q.push_back(mem[8'(a[7:0] + 8'(i))]);
        obs_q = {};
        obs_cyc = {};
        done_cnt = 0;
        mosi_extra = 0;
        rise_tot = 0;
        sif.addr = a;
        sif.len = 16'(l);
        sif.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        sif.start = 1'b0;
        sif.addr = 24'($urandom);
        sif.len = 16'($urandom);
    endtask

    task automatic finish_txn(input logic [23:0] a, input int l, input bit timing);
        int d;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        for (int i = 0; i < 100 && sif.busy !== 1'b0; i++) @(negedge clk);
        d = cyc - done_cyc;
        chk("busy_drop_after_hold", 32'(d >= CS_IDLE && d <= CS_IDLE + 2), 32'd1);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("byte_count", 32'(obs_q.size()), 32'(l));
        for (int i = 0; i < l && i < obs_q.size(); i++) chk("rx_byte", 32'(obs_q[i]), 32'(exp_q[i]));
        chk("cmd_word", cmd_sr, {OPC, a});
        chk("sck_rises", 32'(rise_tot), 32'(HDR + 8 * l));
        chk("mosi_low_after_cmd", 32'(mosi_extra), 32'd0);
        if (timing && obs_cyc.size() == l) begin
            chk("first_strobe_latency", 32'(obs_cyc[0] - t0), 32'(LAT));
            for (int i = 1; i < l; i++) chk("strobe_spacing", 32'(obs_cyc[i] - obs_cyc[i - 1]), 32'(SPACING));
            chk("done_after_last", 32'(done_cyc - obs_cyc[l - 1]), 32'd1);
        end
    endtask

    initial begin
        logic [23:0] a;
        int l;
        int bad;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        reset = 1'b1;
        sif.start = 1'b0;
        sif.addr = '0;
        sif.len = '0;
        space_hold = 1'b1;
        rnd_space = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(sif.busy), 32'd0);
        chk("rst_cs_n", 32'(sif.spi_cs_n), 32'd1);
        chk("rst_sck", 32'(sif.spi_sck), 32'd0);
        chk("rst_mosi", 32'(sif.spi_mosi), 32'd0);
        chk("rst_strobe_data", {22'd0, sif.done, sif.write_strobe, sif.write_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {29'd0, sif.busy, sif.spi_cs_n, sif.spi_sck}, 32'd2);

        // Single byte, known address and data.
        mem[8'h45] = 8'hA5;
        start_txn(24'h012345, 1);
        finish_txn(24'h012345, 1, 1'b1);

        // Four bytes started as soon as busy reads 0.
        a = 24'($urandom);
        mem[8'(a[7:0])] = 8'h11;
        mem[8'(a[7:0] + 8'd1)] = 8'h22;
        mem[8'(a[7:0] + 8'd2)] = 8'h33;
        mem[8'(a[7:0] + 8'd3)] = 8'h44;
        start_txn(a, 4);
        for (int i = 0; i < 50 && sif.spi_cs_n !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
        chk("cs_high_gap", 32'(last_hi_run >= CS_IDLE), 32'd1);
        finish_txn(a, 4, 1'b1);

        // Backpressure stall of 20 cycles before byte 2.
        a = 24'($urandom);
        start_txn(a, 3);
        for (int i = 0; i < 2000 && sif.write_strobe !== 1'b1; i++) @(negedge clk);
        chk("first_strobe_seen", 32'(sif.write_strobe), 32'd1);
        space_hold = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sif.write_strobe !== 1'b0 || sif.spi_sck !== 1'b0 || sif.spi_cs_n !== 1'b0) bad++;
        end
        chk("stall_quiet", 32'(bad), 32'd0);
        space_hold = 1'b1;
        finish_txn(a, 3, 1'b0);

        // Async reset mid-way through byte 3 of 8.
        a = 24'($urandom);
        start_txn(a, 8);
        for (int i = 0; i < 2000 && obs_q.size() < 2; i++) @(negedge clk);
        chk("two_bytes_before_reset", 32'(obs_q.size()), 32'd2);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_cs_n", 32'(sif.spi_cs_n), 32'd1);
        chk("arst_sck", 32'(sif.spi_sck), 32'd0);
        chk("arst_busy", 32'(sif.busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_no_push", 32'(obs_q.size()), 32'd2);
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        a = 24'($urandom);
        l = $urandom_range(1, 5);
        start_txn(a, l);
        finish_txn(a, l, 1'b1);

        // Zero-length start is ignored.
        done_cnt = 0;
        rise_tot = 0;
        sif.addr = 24'($urandom);
        sif.len = 16'd0;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sif.busy !== 1'b0 || sif.spi_cs_n !== 1'b1) bad++;
        end
        chk("len0_quiet", 32'(bad), 32'd0);
        chk("len0_no_done", 32'(done_cnt), 32'd0);
        chk("len0_no_sck", 32'(rise_tot), 32'd0);

        // Start pulsed while busy has no effect.
        a = 24'($urandom);
        start_txn(a, 3);
        repeat (10) @(negedge clk);
        sif.addr = a ^ 24'h00FF00;
        sif.len = 16'd5;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        finish_txn(a, 3, 1'b1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sif.spi_cs_n !== 1'b1) bad++;
        end
        chk("busy_start_ignored", 32'(bad), 32'd0);
        chk("busy_start_one_done", 32'(done_cnt), 32'd1);

        // Random transactions under random backpressure.
        rnd_space = 1'b1;
        for (int t = 0; t < 6; t++) begin
            a = 24'($urandom);
            l = $urandom_range(1, 6);
            start_txn(a, l);
            finish_txn(a, l, 1'b0);
        end
        rnd_space = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
